// File: rtl/cdc_fifo_gray_pkg.sv
// Shared types and Gray-code helpers for both halves of the Gray-pointer CDC FIFO.
// The reader's optional output register is controlled by CDC_FIFO_GRAY_READER_OUTREG_EN.
package cdc_fifo_gray_pkg;

  localparam int unsigned MaxPtrWidth = 32;

  // Helpers run on a wide container; callers slice back to their pointer width.
  typedef logic [MaxPtrWidth-1:0] ptr_max_t;

  localparam ptr_max_t PTR_EMPTY = '0;

  // A pointer carries one extra wrap bit so that full and empty are distinguishable.
  function automatic int unsigned ptr_width(input int unsigned log_depth);
    return log_depth + 1;
  endfunction

  function automatic ptr_max_t binary_to_gray(input ptr_max_t bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic ptr_max_t gray_to_binary(input ptr_max_t gray);
    ptr_max_t bin;
    bin[MaxPtrWidth-1] = gray[MaxPtrWidth-1];
    for (int i = MaxPtrWidth - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/cdc_fifo_gray_reader_gray_ptr_sync.sv
// Multi-flop synchronizer for a Gray-coded pointer, followed by a Gray-to-binary decode.
// Shared by the reader and writer halves of the CDC FIFO.
module gray_ptr_sync
  import cdc_fifo_gray_pkg::*;
#(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] gray_i,
  output logic [WIDTH-1:0] bin_o
);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  ptr_max_t         bin_full;

  // Straight flop chain: no logic between stages.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= gray_i;
      for (int i = 1; i < int'(SYNC_STAGES); i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign bin_full = gray_to_binary(ptr_max_t'(sync_q[SYNC_STAGES-1]));
  assign bin_o    = bin_full[WIDTH-1:0];

endmodule

// File: rtl/cdc_fifo_gray_reader.sv
// Read half of a Gray-pointer CDC FIFO; lives entirely in the destination clock domain.
// Define CDC_FIFO_GRAY_READER_OUTREG_EN to add a one-entry registered output stage.
module cdc_fifo_gray_reader
  import cdc_fifo_gray_pkg::*;
#(
  parameter int unsigned T_w         = 1,
  parameter int unsigned LOG_DEPTH   = 3,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [LOG_DEPTH:0]   async_wptr_gray_i,
  output logic [LOG_DEPTH:0]   async_rptr_gray_o,
  output logic [LOG_DEPTH-1:0] mem_ridx_o,
  input  logic [T_w-1:0]       mem_rdata_i,
  output logic [T_w-1:0]       dst_data_o,
  output logic                 dst_valid_o,
  input  logic                 dst_ready_i,
  output logic [LOG_DEPTH:0]   fill_o
);

  localparam int unsigned PTR_WIDTH = ptr_width(LOG_DEPTH);
  typedef logic [PTR_WIDTH-1:0] ptr_t;
  localparam ptr_t DEPTH = ptr_t'(1 << LOG_DEPTH);

  ptr_t     wptr_bin;
  ptr_t     rptr_bin_q, rptr_bin_d;
  ptr_t     rptr_gray_q, rptr_gray_d;
  ptr_t     rptr_bin_inc;
  ptr_max_t rptr_gray_inc;
  ptr_t     mem_fill;
  logic     mem_valid;
  logic     mem_pop;

  gray_ptr_sync #(
    .WIDTH       (PTR_WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_wptr_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .gray_i (async_wptr_gray_i),
    .bin_o  (wptr_bin)
  );

  assign mem_valid     = (wptr_bin != rptr_bin_q);
  assign mem_fill      = wptr_bin - rptr_bin_q;
  assign rptr_bin_inc  = rptr_bin_q + ptr_t'(1);
  assign rptr_gray_inc = binary_to_gray(ptr_max_t'(rptr_bin_inc));

  always_comb begin
    rptr_bin_d  = rptr_bin_q;
    rptr_gray_d = rptr_gray_q;
    if (mem_pop) begin
      rptr_bin_d  = rptr_bin_inc;
      rptr_gray_d = rptr_gray_inc[PTR_WIDTH-1:0];
    end
  end

  // Gray is registered so the source domain never sees a combinational glitch.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rptr_bin_q  <= PTR_EMPTY[PTR_WIDTH-1:0];
      rptr_gray_q <= PTR_EMPTY[PTR_WIDTH-1:0];
    end else begin
      rptr_bin_q  <= rptr_bin_d;
      rptr_gray_q <= rptr_gray_d;
    end
  end

  assign async_rptr_gray_o = rptr_gray_q;
  assign mem_ridx_o        = rptr_bin_q[LOG_DEPTH-1:0];

`ifdef CDC_FIFO_GRAY_READER_OUTREG_EN
  logic           out_valid_q, out_valid_d;
  logic [T_w-1:0] out_data_q, out_data_d;

  // Refill whenever the register is empty or being drained this cycle.
  assign mem_pop = mem_valid && (!out_valid_q || dst_ready_i);

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (mem_pop) begin
      out_valid_d = 1'b1;
      out_data_d  = mem_rdata_i;
    end else if (dst_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign dst_valid_o = out_valid_q;
  assign dst_data_o  = out_data_q;
  assign fill_o      = mem_fill + {{(PTR_WIDTH-1){1'b0}}, out_valid_q};
`else
  assign mem_pop     = dst_valid_o && dst_ready_i;
  assign dst_valid_o = mem_valid;
  assign dst_data_o  = mem_rdata_i;
  assign fill_o      = mem_fill;
`endif

`ifndef SYNTHESIS
  assert property (@(posedge clk_i) disable iff (!rst_ni) mem_fill <= DEPTH)
    else $error("storage fill exceeds depth: %0d", mem_fill);
`endif

endmodule

// File: tb/tb_cdc_fifo_gray_reader.sv
// Directed self-checking bench for cdc_fifo_gray_reader (LOG_DEPTH=3, SYNC_STAGES=2, T_w=8).
module tb_cdc_fifo_gray_reader;

  localparam int unsigned T_w         = 8;
  localparam int unsigned LOG_DEPTH   = 3;
  localparam int unsigned SYNC_STAGES = 2;

  logic                 clk;
  logic                 rst_n;
  logic [LOG_DEPTH:0]   wptr_gray;
  logic [LOG_DEPTH:0]   rptr_gray;
  logic [LOG_DEPTH-1:0] ridx;
  logic [T_w-1:0]       rdata;
  logic [T_w-1:0]       data;
  logic                 valid;
  logic                 ready;
  logic [LOG_DEPTH:0]   fill;

  logic [T_w-1:0] mem [8];
  int n_checks;
  int n_fail;

  assign rdata = mem[ridx];

  cdc_fifo_gray_reader #(
    .T_w         (T_w),
    .LOG_DEPTH   (LOG_DEPTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .async_wptr_gray_i (wptr_gray),
    .async_rptr_gray_o (rptr_gray),
    .mem_ridx_o        (ridx),
    .mem_rdata_i       (rdata),
    .dst_data_o        (data),
    .dst_valid_o       (valid),
    .dst_ready_i       (ready),
    .fill_o            (fill)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    wptr_gray = 4'b0000;
    ready     = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid); end
    n_checks++; if (rptr_gray !== 4'b0000) begin n_fail++; $display("FAIL reset_rptr: got %b want 0000", rptr_gray); end
    n_checks++; if (ridx !== 3'd0) begin n_fail++; $display("FAIL reset_ridx: got %0d want 0", ridx); end
    n_checks++; if (fill !== 4'd0) begin n_fail++; $display("FAIL reset_fill: got %0d want 0", fill); end
`ifndef CDC_FIFO_GRAY_READER_OUTREG_EN
    n_checks++; if (data !== 8'hA0) begin n_fail++; $display("FAIL reset_data: got %h want a0", data); end
`endif
  endtask

  task automatic test_latency();
    ready     = 1'b1;
    wptr_gray = 4'b0001;
    tick();
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL lat_edge1_valid: got %b want 0", valid); end
    tick();
    n_checks++; if (valid !== 1'b1) begin n_fail++; $display("FAIL lat_edge2_valid: got %b want 1", valid); end
    n_checks++; if (fill !== 4'd1) begin n_fail++; $display("FAIL lat_fill: got %0d want 1", fill); end
    n_checks++; if (data !== 8'hA0) begin n_fail++; $display("FAIL lat_data: got %h want a0", data); end
    tick();
    n_checks++; if (rptr_gray !== 4'b0001) begin n_fail++; $display("FAIL lat_pop_rptr: got %b want 0001", rptr_gray); end
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL lat_pop_valid: got %b want 0", valid); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    wptr_gray = 4'b1100;
    tick();
    tick();
    n_checks++; if (fill !== 4'd8) begin n_fail++; $display("FAIL b2b_fill: got %0d want 8", fill); end
    ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      n_checks++; if (ridx !== 3'(i)) begin n_fail++; $display("FAIL b2b_ridx[%0d]: got %0d want %0d", i, ridx, i); end
      n_checks++; if (data !== 8'hA0 + 8'(i)) begin n_fail++; $display("FAIL b2b_data[%0d]: got %h want %h", i, data, 8'hA0 + 8'(i)); end
      n_checks++; if (valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid[%0d]: got %b want 1", i, valid); end
      tick();
    end
    n_checks++; if (rptr_gray !== 4'b1100) begin n_fail++; $display("FAIL b2b_rptr: got %b want 1100", rptr_gray); end
    n_checks++; if (fill !== 4'd0) begin n_fail++; $display("FAIL b2b_end_fill: got %0d want 0", fill); end
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL b2b_end_valid: got %b want 0", valid); end
    // Ready with nothing visible must not move the pointer.
    tick();
    tick();
    n_checks++; if (rptr_gray !== 4'b1100) begin n_fail++; $display("FAIL idle_ready_rptr: got %b want 1100", rptr_gray); end
  endtask

  task automatic test_wrap();
    ready     = 1'b0;
    wptr_gray = 4'b1000;  // bin 15
    tick();
    tick();
    n_checks++; if (fill !== 4'd7) begin n_fail++; $display("FAIL wrap_fill7: got %0d want 7", fill); end
    ready = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    n_checks++; if (rptr_gray !== 4'b1000) begin n_fail++; $display("FAIL wrap_rptr15: got %b want 1000", rptr_gray); end
    ready     = 1'b0;
    wptr_gray = 4'b0000;  // bin 16 mod 16
    tick();
    tick();
    n_checks++; if (fill !== 4'd1) begin n_fail++; $display("FAIL wrap_fill1: got %0d want 1", fill); end
    n_checks++; if (valid !== 1'b1) begin n_fail++; $display("FAIL wrap_valid: got %b want 1", valid); end
    n_checks++; if (ridx !== 3'd7) begin n_fail++; $display("FAIL wrap_ridx: got %0d want 7", ridx); end
    ready = 1'b1;
    tick();
    n_checks++; if (rptr_gray !== 4'b0000) begin n_fail++; $display("FAIL wrap_rptr0: got %b want 0000", rptr_gray); end
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL wrap_end_valid: got %b want 0", valid); end
  endtask

  task automatic test_backpressure();
    ready     = 1'b0;
    wptr_gray = 4'b0010;  // bin 3
    tick();
    tick();
    n_checks++; if (fill !== 4'd3) begin n_fail++; $display("FAIL bp_fill: got %0d want 3", fill); end
    for (int i = 0; i < 10; i++) begin
      tick();
      n_checks++;
      if (valid !== 1'b1 || data !== 8'hA0 || ridx !== 3'd0 || rptr_gray !== 4'b0000) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got v=%b d=%h i=%0d r=%b want v=1 d=a0 i=0 r=0000",
                 i, valid, data, ridx, rptr_gray);
      end
    end
  endtask

  task automatic test_reset_midstream();
    wptr_gray = 4'b0111;  // bin 5
    tick();
    tick();
    n_checks++; if (fill !== 4'd5) begin n_fail++; $display("FAIL mid_pre_fill: got %0d want 5", fill); end
    ready = 1'b1;
    tick();  // one pop so the pointer is non-zero
    rst_n = 1'b0;
    #1;
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid: got %b want 0", valid); end
    n_checks++; if (rptr_gray !== 4'b0000) begin n_fail++; $display("FAIL mid_rst_rptr: got %b want 0000", rptr_gray); end
    n_checks++; if (ridx !== 3'd0) begin n_fail++; $display("FAIL mid_rst_ridx: got %0d want 0", ridx); end
    n_checks++; if (fill !== 4'd0) begin n_fail++; $display("FAIL mid_rst_fill: got %0d want 0", fill); end
    wptr_gray = 4'b0000;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_outreg();
    do_reset();
    wptr_gray = 4'b0001;
    tick();
    tick();
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL or_edge2_valid: got %b want 0", valid); end
    n_checks++; if (rptr_gray !== 4'b0000) begin n_fail++; $display("FAIL or_edge2_rptr: got %b want 0000", rptr_gray); end
    tick();
    n_checks++; if (valid !== 1'b1) begin n_fail++; $display("FAIL or_edge3_valid: got %b want 1", valid); end
    n_checks++; if (rptr_gray !== 4'b0001) begin n_fail++; $display("FAIL or_edge3_rptr: got %b want 0001", rptr_gray); end
    n_checks++; if (fill !== 4'd1) begin n_fail++; $display("FAIL or_fill: got %0d want 1", fill); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (valid !== 1'b1 || data !== 8'hA0) begin
        n_fail++; $display("FAIL or_hold[%0d]: got v=%b d=%h want v=1 d=a0", i, valid, data);
      end
    end
    ready = 1'b1;
    tick();
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL or_pop_valid: got %b want 0", valid); end
    n_checks++; if (fill !== 4'd0) begin n_fail++; $display("FAIL or_pop_fill: got %0d want 0", fill); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < 8; i++) mem[i] = 8'hA0 + 8'(i);
    rst_n     = 1'b0;
    wptr_gray = '0;
    ready     = 1'b0;
    test_reset();
`ifdef CDC_FIFO_GRAY_READER_OUTREG_EN
    test_outreg();
`else
    test_latency();
    test_back_to_back();
    test_wrap();
    test_backpressure();
    test_reset_midstream();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cdc_fifo_gray_reader.md
Name: cdc_fifo_gray_reader

Overview:
Destination-side (read) half of a Gray-pointer clock-domain-crossing FIFO, running entirely in the destination clock domain.
- Inputs: the source half's Gray-coded write pointer (asynchronous to clk_i) and the read port of a 2**LOG_DEPTH-entry storage array owned by the source half.
- Actions: synchronizes the write pointer, maintains the read pointer, and exports the read pointer back as Gray code.
- Outputs: a valid/ready stream plus a fill level.

Parameters:
- T_w, 1, payload width in bits.
- LOG_DEPTH, 3, FIFO depth is 2**LOG_DEPTH; must be >= 1.
- SYNC_STAGES, 2, flops in the write-pointer synchronizer; must be >= 2.

Ports:
- clk_i  input  1  destination-domain clock.
- rst_ni  input  1  asynchronous active-low reset.
- async_wptr_gray_i  input  LOG_DEPTH+1  Gray write pointer from the source domain (asynchronous).
- async_rptr_gray_o  output  LOG_DEPTH+1  registered Gray read pointer, to the source domain.
- mem_ridx_o  output  LOG_DEPTH  storage read index.
- mem_rdata_i  input  T_w  storage read data, combinational from mem_ridx_o.
- dst_data_o  output  T_w  payload.
- dst_valid_o  output  1  payload valid.
- dst_ready_i  input  1  consumer ready.
- fill_o  output  LOG_DEPTH+1  entries held, 0..2**LOG_DEPTH.

Behaviour:
- Clock and reset: single clock clk_i; reset rst_ni is asynchronous, active-low. All flops reset to '0.
- Outputs in reset: dst_valid_o=0, async_rptr_gray_o=0, mem_ridx_o=0, fill_o=0. dst_data_o follows mem_rdata_i (entry 0).
- Synchronizer:
  - async_wptr_gray_i passes through SYNC_STAGES flops, no logic in between.
  - The last stage is Gray-decoded to wptr_bin.
- Read pointer:
  - rptr_bin_q and rptr_gray_q are PTR_WIDTH = LOG_DEPTH+1 bits.
  - Pop = dst_valid_o && dst_ready_i.
  - On pop: rptr_bin_q <= rptr_bin_q+1 (mod 2**PTR_WIDTH) and rptr_gray_q <= gray(rptr_bin_q+1). The Gray value is registered, never combinational.
  - async_rptr_gray_o = rptr_gray_q; changes at most one bit per cycle.
- Index and data: mem_ridx_o = rptr_bin_q[LOG_DEPTH-1:0]; dst_data_o = mem_rdata_i (fall-through).
- Empty: dst_valid_o = (wptr_bin != rptr_bin_q).
- Fill: fill_o = wptr_bin - rptr_bin_q (mod 2**PTR_WIDTH). fill_o > 2**LOG_DEPTH is an assertion failure (simulation only).
- Latency: a write pointer change is visible on dst_valid_o exactly SYNC_STAGES clk_i edges after it is stable at the input.
- Throughput: 1 pop/cycle while data is visible.
- Backpressure: dst_valid_o && !dst_ready_i holds dst_data_o, mem_ridx_o and the pointers stable.
- dst_ready_i while !dst_valid_o: no effect.
- Wrap-around: pointer 2**PTR_WIDTH-1 -> 0. Binary and Gray both wrap; the top bit distinguishes full from empty.
- Simultaneous events: pop in the same cycle as a synchronized write-pointer update: dst_valid_o for the next cycle uses the new wptr_bin and the incremented rptr.
- Reset mid-operation: the pointer returns to 0 immediately. The source half must be reset in the same reset window; a one-sided reset is unsupported.

Optional Feature:
Macro CDC_FIFO_GRAY_READER_OUTREG_EN.
- Defined: a one-entry output register sits between storage and the stream.
  - Transfer from storage when the storage side is non-empty and (register empty or register popped this cycle).
  - The read pointer advances on transfer, so the slot is freed one cycle earlier.
  - dst_data_o and dst_valid_o are driven directly from flops.
  - First-data latency is SYNC_STAGES+1; throughput stays 1/cycle.
  - fill_o = storage entries + register occupancy.
- Undefined: fall-through behaviour as above.

Decomposition:
- Package cdc_fifo_gray_pkg:
  - ptr_width(LOG_DEPTH) function.
  - Pointer/index typedef guidance.
  - Reset constant PTR_EMPTY='0.
  - Shared by this block and the future writer half.
- Sub-module gray_ptr_sync: parameterized SYNC_STAGES-flop Gray synchronizer plus gray_to_binary. It is reused by the writer half.
- Existing binary_to_gray / gray_to_binary cells are used; no re-implementation.

Test Plan (LOG_DEPTH=3, SYNC_STAGES=2, macro undefined unless stated):
1. Assert rst_ni=0 mid-stream with fill_o=5 -> immediately dst_valid_o=0, async_rptr_gray_o=4'b0000, mem_ridx_o=0, fill_o=0.
2. async_wptr_gray_i 0000->0001, ready=1 -> dst_valid_o=1 after exactly 2 edges, fill_o=1. Pop next edge -> async_rptr_gray_o=0001, dst_valid_o=0.
3. async_wptr_gray_i=1100 (bin 8), ready=1 -> fill_o=8. 8 back-to-back beats with mem_ridx_o 0..7. async_rptr_gray_o ends at 1100; fill_o=0, valid=0.
4. Wrap: rptr=15 (gray 1000), wptr gray 0000 (bin 16 mod 16 = 0) -> fill_o=1. Pop -> async_rptr_gray_o=0000, valid=0.
5. Backpressure: fill_o=3, ready=0 for 10 cycles -> dst_data_o, mem_ridx_o and async_rptr_gray_o are constant, and valid stays 1.
6. With CDC_FIFO_GRAY_READER_OUTREG_EN: wptr 0000->0001 -> valid after 3 edges. async_rptr_gray_o=0001 one cycle before the dst handshake; dst_data_o stays stable while ready=0.
